// File: rtl/mem_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Brief    : Shared I/O map constants and decode helpers for mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam logic [17:0] IO_BASE        = 18'h30000;
    localparam logic [2:0]  IO_DATA_OFFSET = 3'd0;
    localparam logic [2:0]  IO_HALT_OFFSET = 3'd4;

    localparam int STATUS_BUF_FULL_BIT    = 0;
    localparam int STATUS_RX_NONEMPTY_BIT = 1;
    localparam int STATUS_TX_OVERFLOW_BIT = 2;

    typedef enum logic [1:0] {
        IO_REG_DATA = 2'd0,
        IO_REG_HALT = 2'd1,
        IO_REG_NONE = 2'd2
    } io_reg_e;

    // The window is selected by the top two decoded address bits only.
    function automatic logic is_io_window(input logic [1:0] addr_hi);
        return addr_hi == IO_BASE[17:16];
    endfunction

    function automatic io_reg_e decode_io_reg(input logic [2:0] offset);
        io_reg_e r;
        case (offset)
            IO_DATA_OFFSET: r = IO_REG_DATA;
            IO_HALT_OFFSET: r = IO_REG_HALT;
            default:        r = IO_REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] build_status(input logic tx_overflow,
                                                input logic rx_nonempty,
                                                input logic buf_full);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_TX_OVERFLOW_BIT] = tx_overflow;
        s[STATUS_RX_NONEMPTY_BIT] = rx_nonempty;
        s[STATUS_BUF_FULL_BIT]    = buf_full;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with wrapping pointers and an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Byte RAM plus console/status/halt I/O window on the memory bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow,
    output logic        sim_halt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_near_full = CNT_W'(FIFO_DEPTH - 2);

    logic [7:0]            r_ram [2**ADDR_WIDTH];
    logic [7:0]            r_mem_dout;
    logic                  r_tx_overflow;
    logic                  r_sim_halt;

    logic                  w_io_sel;
    io_reg_e               w_io_reg;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_bus_wr;
    logic                  w_bus_rd;
    logic                  w_unused_addr;

    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_drop;
    logic [7:0]            w_tx_head;
    logic [CNT_W-1:0]      w_tx_count;
    logic                  w_tx_full;
    logic                  w_tx_empty;

    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic [7:0]            w_rx_head;
    logic [CNT_W-1:0]      w_rx_count;
    logic                  w_rx_full;
    logic                  w_rx_empty;

    logic [7:0]            w_rd_data;

    assign w_io_sel      = is_io_window(mem_a[17:16]);
    assign w_io_reg      = decode_io_reg(mem_a[2:0]);
    assign w_ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign w_bus_wr      = rdy & mem_wr;
    assign w_bus_rd      = rdy & ~mem_wr;
    assign w_unused_addr = &{1'b0, mem_a[31:18], w_rx_count};

    assign w_tx_push = w_bus_wr & w_io_sel & (w_io_reg == IO_REG_DATA);
    assign w_tx_pop  = rdy & tx_valid & tx_ready;
    assign w_tx_drop = w_tx_push & w_tx_full & ~w_tx_pop;

    // An empty RX read returns zero and must not advance the read pointer.
    assign w_rx_push = rdy & rx_valid & rx_ready;
    assign w_rx_pop  = w_bus_rd & w_io_sel & (w_io_reg == IO_REG_DATA) & ~w_rx_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (mem_din),
        .pop       (w_tx_pop),
        .head      (w_tx_head),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_rx_push),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .head      (w_rx_head),
        .count     (w_rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    assign tx_data        = w_tx_head;
    assign tx_valid       = ~w_tx_empty;
    assign rx_ready       = ~w_rx_full;
    assign io_buffer_full = (w_tx_count >= c_near_full);
    assign tx_overflow    = r_tx_overflow;
    assign sim_halt       = r_sim_halt;
    assign mem_dout       = r_mem_dout;

    always_comb begin
        w_rd_data = 8'h00;
        if (w_io_sel) begin
            case (w_io_reg)
                IO_REG_DATA: w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
                IO_REG_HALT: w_rd_data = build_status(r_tx_overflow, ~w_rx_empty,
                                                      io_buffer_full);
                default:     w_rd_data = 8'h00;
            endcase
        end else begin
            w_rd_data = r_ram[w_ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_dout    <= 8'h00;
            r_tx_overflow <= 1'b0;
            r_sim_halt    <= 1'b0;
        end else if (rdy) begin
            if (!mem_wr) r_mem_dout <= w_rd_data;
            if (w_tx_drop) r_tx_overflow <= 1'b1;
            if (mem_wr && w_io_sel && (w_io_reg == IO_REG_HALT)) r_sim_halt <= 1'b1;
        end
    end

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && w_bus_wr && !w_io_sel) r_ram[w_ram_idx] <= mem_din;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder on the byte-serial memory bus driven by the CPU memory controller (mem_a, mem_wr, mem_din, mem_dout).
- Provides a single-ported byte RAM plus a memory-mapped I/O window.
- The I/O window holds a TX byte FIFO (console out), an RX byte FIFO (console in), a status register and a halt register.
- Used as the RAM/IO model in simulation and as the bus endpoint on the FPGA top.

Parameters:
- ADDR_WIDTH, 17, RAM index width; RAM is 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, at least 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, the bus is ignored and state is frozen
- mem_a  in  32  byte address from the controller; only bits 17:0 are decoded
- mem_wr  in  1  1 = write mem_din at mem_a this cycle; 0 = read
- mem_din  in  8  write data from the controller
- mem_dout  out  8  registered read data
- io_buffer_full  out  1  TX FIFO nearly full; the controller must stall I/O writes
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  sink accepts tx_data this cycle
- rx_data  in  8  incoming console byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO not full
- tx_overflow  out  1  sticky; a TX write was dropped because the FIFO was full
- sim_halt  out  1  sticky; the program wrote the halt register

Behaviour:
- Address decode: io_sel = (mem_a[17:16] == 2'b11). Otherwise RAM, index mem_a[ADDR_WIDTH-1:0].
- All bus actions occur on posedge clk, only when rdy == 1 and rst == 0.
- Read latency: mem_a is sampled at edge k and mem_dout is registered at edge k. Data is valid from edge k until edge k+1, so a controller that sets mem_a at edge k-1 reads the byte at edge k+1.
- RAM read: mem_dout <= ram[idx].
- RAM write (mem_wr = 1): ram[idx] <= mem_din. mem_dout holds its previous value.
- I/O map, decoded on mem_a[2:0] within the window:
  - 0x30000 write: push mem_din into TX. If TX is full, drop the byte and set tx_overflow.
  - 0x30000 read: mem_dout <= RX head and pop. If RX is empty, mem_dout <= 8'h00 with no pop.
  - 0x30004 write: sim_halt <= 1. The data byte is ignored.
  - 0x30004 read: mem_dout <= {5'b0, tx_overflow, rx_nonempty, io_buffer_full}.
  - Any other I/O offset: reads return 8'h00; writes are ignored.
- Repeated reads: the controller issues one address per cycle, so a 4-byte read of 0x30000 pops only once. Bytes at 0x30001..0x30003 are "other offsets" and return 0.
- TX FIFO:
  - Push: bus write to 0x30000. Pop: tx_valid & tx_ready.
  - Push and pop in the same cycle when full: the pop frees a slot and the push is accepted, so count is unchanged and no overflow occurs.
  - io_buffer_full = (tx_count >= FIFO_DEPTH-2), combinational from the registered count. This gives two bytes of headroom for writes already in flight.
- RX FIFO:
  - Push: rx_valid & rx_ready, where rx_ready = !rx_full. Pop: bus read of 0x30000.
  - Pop and push in the same cycle when empty: the read returns 0, no pop occurs, and the byte is stored.
- rdy low: no RAM or FIFO change from the bus, and mem_dout holds. The tx/rx handshakes are also frozen (no push or pop), so tx_valid and rx_ready hold their values.
- Reset (synchronous): mem_dout = 0, both FIFOs empty (tx_valid = 0, rx_ready = 1), io_buffer_full = 0, tx_overflow = 0, sim_halt = 0. RAM contents are not cleared.
- Reset mid-operation: any bus or FIFO action in the reset cycle is discarded.
- Halt: sim_halt stays 1 until rst. The bus and FIFOs keep operating after halt, so TX continues to drain.
- Pointer arithmetic: the FIFOs use log2(FIFO_DEPTH)-bit pointers that wrap modulo depth, plus a (log2+1)-bit count.

Decomposition:
- Shared constants header: IO_BASE = 18'h30000, IO_HALT_OFFSET = 3'd4, IO_DATA_OFFSET = 3'd0, STATUS bit positions.
- Sub-module: sync_fifo (params WIDTH, DEPTH).
  - Ports: push, push_data, pop, head, count, full, empty.
  - Instantiated twice, for TX and RX.
- RAM: inferred single-port array inside mem_responder.

Test Plan:
- RAM byte path: write 0x00010..0x00013 = 11,22,33,44, then read 0x00010..0x00013 on back-to-back cycles -> mem_dout = 11,22,33,44, each one edge after its address.
- TX overflow: with tx_ready = 0, write 0x41 ten times to 0x30000 (depth 8) -> io_buffer_full rises after the 6th write, tx_overflow = 1 after the 9th, tx_count = 8. Then set tx_ready = 1 -> 8 bytes of 0x41 drain and tx_valid falls.
- RX read: push 0x5A, 0x5B via rx_valid, then read 0x30000 three times -> 5A, 5B, 00. Read 0x30004 -> 8'h00.
- Simultaneous TX: with TX full, tx_ready = 1 and a bus write of 0x7E in the same cycle -> count stays 8, tx_overflow stays 0, and 0x7E is dequeued last.
- Halt and rdy: write 0x30004 with rdy = 0 -> sim_halt stays 0. Repeat with rdy = 1 -> sim_halt = 1 and stays 1. Assert rst -> sim_halt = 0, mem_dout = 0, and RAM contents are preserved on re-read.
